// File: rtl/mat_io_pkg.sv
// Shared types and sizing for the matrix load/multiply/read-back path.
// The result word width is common to the loader, multiplier and unloader.
package mat_io_pkg;

    localparam int RES_W          = 64;
    localparam int ELEM_W         = 16;
    localparam int MAX_ELEMS      = 4;
    localparam int BYTES_PER_ELEM = ELEM_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

endpackage

// File: rtl/result_unloader_if.sv
// Result capture inputs plus the byte-wide valid/ready output stream and status flags.
// master = unloader side, slave = multiplier/consumer side.
interface result_unloader_if;
    import mat_io_pkg::*;

    logic [RES_W-1:0] res_mat;
    logic             res_valid;
    logic [3:0]       res_rows;
    logic [3:0]       res_cols;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             err_size;
    logic             err_overrun;

    modport master (
        input  res_mat, res_valid, res_rows, res_cols, out_ready,
        output out_data, out_valid, out_last, busy, err_size, err_overrun
    );

    modport slave (
        output res_mat, res_valid, res_rows, res_cols, out_ready,
        input  out_data, out_valid, out_last, busy, err_size, err_overrun
    );

endinterface

// File: rtl/result_unloader_byte_shifter.sv
// Result word register: parallel load, shift left by one byte, top byte exposed.
// Load has priority over shift; synchronous active-high reset clears it.
module byte_shifter
    import mat_io_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [RES_W-1:0] load_val,
    output logic [7:0]       top_byte
);

    logic [RES_W-1:0] sreg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= load_val;
        end else if (shift) begin
            sreg <= {sreg[RES_W-9:0], 8'h00};
        end
    end

    assign top_byte = sreg[RES_W-1 -: 8];

endmodule

// File: rtl/result_unloader.sv
// Captures the result word on a res_valid rising edge and streams it out MSB byte first; first byte the cycle after capture, one byte/cycle, held stable under backpressure.
// RESULT_CHECKSUM_EN appends an XOR checksum byte carrying out_last.
module result_unloader #(
    parameter int ELEM_W    = mat_io_pkg::ELEM_W,
    parameter int MAX_ELEMS = mat_io_pkg::MAX_ELEMS
) (
    input  logic               CLK,
    input  logic               RST,
    result_unloader_if.master  bus
);
    import mat_io_pkg::*;

    localparam int BPE = ELEM_W / 8;

    state_t           state_q, state_nxt;
    logic             prev_q;
    logic             rise, xfer;
    logic [7:0]       n_raw, n_cl, nbytes;
    logic [7:0]       cnt_q, cnt_nxt;
    logic             valid_q, valid_nxt;
    logic             last_q, last_nxt;
    logic             busy_q, busy_nxt;
    logic             esize_q, esize_nxt;
    logic             eovr_q, eovr_nxt;
    logic             sh_load, sh_shift;
    logic [RES_W-1:0] sh_val;
    logic [7:0]       top_byte;
`ifdef RESULT_CHECKSUM_EN
    logic [7:0]       csum_q, csum_nxt;
`endif

    // prev resets high so a level already asserted at reset release is ignored
    assign rise   = bus.res_valid & ~prev_q;
    assign xfer   = valid_q & bus.out_ready;
    assign n_raw  = {4'd0, bus.res_rows} * {4'd0, bus.res_cols};
    assign n_cl   = (n_raw > 8'(MAX_ELEMS)) ? 8'(MAX_ELEMS) : n_raw;
    assign nbytes = 8'(n_cl * BPE);

    byte_shifter u_shifter (
        .CLK      (CLK),
        .RST      (RST),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_val (sh_val),
        .top_byte (top_byte)
    );

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        valid_nxt = valid_q;
        last_nxt  = last_q;
        busy_nxt  = busy_q;
        esize_nxt = esize_q;
        eovr_nxt  = eovr_q | (rise & busy_q);
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_val    = bus.res_mat;
`ifdef RESULT_CHECKSUM_EN
        csum_nxt  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise) begin
                    if (n_raw > 8'(MAX_ELEMS)) esize_nxt = 1'b1;
`ifdef RESULT_CHECKSUM_EN
                    csum_nxt = 8'h00;
                    if (n_cl == 8'd0) begin
                        // empty frame still emits the checksum byte (0x00)
                        state_nxt = CSUM;
                        sh_load   = 1'b1;
                        sh_val    = '0;
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = SEND;
                        sh_load   = 1'b1;
                        cnt_nxt   = nbytes;
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        last_nxt  = 1'b0;
                    end
`else
                    if (n_cl != 8'd0) begin
                        state_nxt = SEND;
                        sh_load   = 1'b1;
                        cnt_nxt   = nbytes;
                        valid_nxt = 1'b1;
                        busy_nxt  = 1'b1;
                        last_nxt  = (nbytes == 8'd1);
                    end
`endif
                end
            end
            SEND: begin
                if (xfer) begin
`ifdef RESULT_CHECKSUM_EN
                    csum_nxt = csum_q ^ top_byte;
`endif
                    if (cnt_q == 8'd1) begin
`ifdef RESULT_CHECKSUM_EN
                        state_nxt = CSUM;
                        sh_load   = 1'b1;
                        sh_val    = {csum_q ^ top_byte, {(RES_W-8){1'b0}}};
                        last_nxt  = 1'b1;
`else
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        busy_nxt  = 1'b0;
                        last_nxt  = 1'b0;
`endif
                    end else begin
                        cnt_nxt  = cnt_q - 8'd1;
                        sh_shift = 1'b1;
`ifndef RESULT_CHECKSUM_EN
                        last_nxt = (cnt_q == 8'd2);
`endif
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    busy_nxt  = 1'b0;
                    last_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            esize_q <= 1'b0;
            eovr_q  <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_nxt;
            prev_q  <= bus.res_valid;
            cnt_q   <= cnt_nxt;
            valid_q <= valid_nxt;
            last_q  <= last_nxt;
            busy_q  <= busy_nxt;
            esize_q <= esize_nxt;
            eovr_q  <= eovr_nxt;
`ifdef RESULT_CHECKSUM_EN
            csum_q  <= csum_nxt;
`endif
        end
    end

    assign bus.out_data    = top_byte;
    assign bus.out_valid   = valid_q;
    assign bus.out_last    = last_q;
    assign bus.busy        = busy_q;
    assign bus.err_size    = esize_q;
    assign bus.err_overrun = eovr_q;

endmodule

// File: tb/tb_result_unloader.sv
// Directed plus randomized frames checked against a byte-list reference model.
module tb_result_unloader;
    import mat_io_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    result_unloader_if bus ();

    result_unloader #(.ELEM_W(16), .MAX_ELEMS(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       exp_esize;
    logic       exp_eovr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: rows*cols elements (clamped), each ELEM_W/8 bytes, MSB first.
    task automatic build_expected(input logic [63:0] mat, input logic [3:0] r, input logic [3:0] c);
        int n;
        logic [7:0] x;
        n = int'(r) * int'(c);
        if (n > 4) begin
            n = 4;
            exp_esize = 1'b1;
        end
        exp_q = {};
        x = 8'h00;
        for (int i = 0; i < n * 2; i++) begin
            exp_q.push_back(8'((mat >> (56 - 8 * i)) & 64'hFF));
            x = x ^ exp_q[i];
        end
`ifdef RESULT_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic start_frame(input logic [63:0] mat, input logic [3:0] r, input logic [3:0] c);
        @(negedge CLK);
        bus.res_valid = 1'b0;
        @(negedge CLK);
        bus.res_mat   = mat;
        bus.res_rows  = r;
        bus.res_cols  = c;
        bus.res_valid = 1'b1;
        build_expected(mat, r, c);
    endtask

    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready
    task automatic run_frame(input string tag, input int mode, input int stop_after, input int pulse_at);
        int         idx = 0;
        int         cyc = 0;
        int         lim;
        bit         stalled = 0;
        bit         rdy;
        logic [7:0] hd = 8'h00;
        logic       hl = 1'b0;
        lim = (stop_after < 0) ? exp_q.size() : stop_after;
        while (idx < lim && cyc < 200) begin
            @(negedge CLK);
            if (pulse_at >= 0 && cyc == pulse_at) bus.res_valid = 1'b0;
            if (pulse_at >= 0 && cyc == pulse_at + 1) begin
                bus.res_valid = 1'b1;
                bus.res_mat   = {$urandom, $urandom};
                exp_eovr      = 1'b1;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid) begin
                if (stalled) begin
                    check({tag, "_stall_data"}, 64'(bus.out_data), 64'(hd));
                    check({tag, "_stall_last"}, 64'(bus.out_last), 64'(hl));
                end
                if (rdy) begin
                    check({tag, "_data"}, 64'(bus.out_data), 64'(exp_q[idx]));
                    check({tag, "_last"}, 64'(bus.out_last), 64'(idx == exp_q.size() - 1));
                    idx++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hd = bus.out_data;
                    hl = bus.out_last;
                end
            end
            cyc++;
        end
        check({tag, "_count"}, 64'(idx), 64'(lim));
        if (mode == 0) check({tag, "_cycles"}, 64'(cyc), 64'(lim));
    endtask

    task automatic finish_check(input string tag);
        @(negedge CLK);
        check({tag, "_end_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_end_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_end_last"}, 64'(bus.out_last), 64'(0));
        check({tag, "_err_size"}, 64'(bus.err_size), 64'(exp_esize));
        check({tag, "_err_ovr"}, 64'(bus.err_overrun), 64'(exp_eovr));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, 64'(bus.out_data), 64'(0));
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_last"}, 64'(bus.out_last), 64'(0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_esize"}, 64'(bus.err_size), 64'(0));
        check({tag, "_eovr"}, 64'(bus.err_overrun), 64'(0));
    endtask

    initial begin
        logic [63:0] vec;
        vec           = 64'h0102_0304_0506_0708;
        exp_esize     = 1'b0;
        exp_eovr      = 1'b0;
        RST           = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_mat   = vec;
        bus.res_rows  = 4'd2;
        bus.res_cols  = 4'd2;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;
        // level already high at reset release must not start a frame
        repeat (3) @(negedge CLK);
        check("no_send_at_release_valid", 64'(bus.out_valid), 64'(0));
        check("no_send_at_release_busy", 64'(bus.busy), 64'(0));

        start_frame(vec, 4'd2, 4'd2);
        run_frame("f2x2", 0, -1, -1);
        finish_check("f2x2");

        start_frame(vec, 4'd1, 4'd2);
        run_frame("f1x2", 0, -1, -1);
        finish_check("f1x2");

        start_frame(vec, 4'd2, 4'd2);
        run_frame("fstall", 1, -1, -1);
        finish_check("fstall");

        start_frame(vec, 4'd3, 4'd3);
        run_frame("f3x3_ovr", 0, -1, 1);
        finish_check("f3x3_ovr");

        start_frame(64'hA1B2_C3D4_E5F6_0718, 4'd1, 4'd1);
        run_frame("f1x1", 2, -1, -1);
        finish_check("f1x1");

        // reset in the middle of a frame
        start_frame(vec, 4'd2, 4'd2);
        run_frame("fmid", 0, 3, -1);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midrst");
        exp_esize = 1'b0;
        exp_eovr  = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        check("midrst_no_resend", 64'(bus.out_valid), 64'(0));
        start_frame(vec, 4'd2, 4'd2);
        run_frame("fresh", 2, -1, -1);
        finish_check("fresh");

        for (int k = 0; k < 25; k++) begin
            start_frame({$urandom, $urandom}, 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
            run_frame("rand", int'($urandom_range(0, 2)), -1, -1);
            finish_check("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
